// File: rtl/rtt_pkg.sv
// Shared definitions for the reaction-time tester display path:
// scanner states, active-low 7-segment patterns and digit count.
package rtt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    localparam int NUM_DIGITS = 4;

    // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

endpackage

// File: rtl/rtt_seg7_decode.sv
// Combinational BCD to active-low 7-segment decoder; non-decimal codes
// show a dash so a corrupted value is visible rather than silently wrong.
module rtt_seg7_decode
    import rtt_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (code)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/rtt_display_scanner.sv
// Four-digit multiplexed 7-segment scanner with blank intervals between
// digits, leading-zero blanking and a frame-synchronised double buffer.
module rtt_display_scanner
    import rtt_pkg::*;
#(
    parameter int DIGIT_TICKS = 50000,
    parameter int BLANK_TICKS = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] bcd_in,
    input  logic        load_req,
    output logic        load_ack,
    input  logic        lzb_en,
    input  logic        blank_all,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        frame_start
);

    localparam int MAX_TICKS = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
    localparam int CW        = $clog2(MAX_TICKS);
    localparam int IW        = $clog2(NUM_DIGITS);

    localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_TICKS - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_TICKS - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    state_t        state, state_next;
    logic [IW-1:0] idx, idx_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          boundary;

    logic [15:0]   shadow, active;
    logic          pending;
    logic          capture;

    logic [3:0]    digit_code;
    logic [6:0]    digit_seg;
    logic [3:0]    lz_mask;
    logic          show_on;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        cnt_next   = cnt;
        boundary   = 1'b0;
        if (!en) begin
            state_next = IDLE;
            idx_next   = '0;
            cnt_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_next = BLANK;
                    idx_next   = '0;
                    cnt_next   = '0;
                    boundary   = 1'b1;
                end
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state_next = SHOW;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                SHOW: begin
                    if (cnt == DIGIT_LAST) begin
                        state_next = BLANK;
                        cnt_next   = '0;
                        idx_next   = idx + 1'b1;
                        boundary   = (idx == IDX_LAST);
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    idx_next   = '0;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // A held request alternates capture/ack, so it recaptures every second cycle.
    assign capture = load_req && !load_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow   <= '0;
            active   <= '0;
            pending  <= 1'b0;
            load_ack <= 1'b0;
        end else begin
            load_ack <= capture;
            if (capture) begin
                shadow <= bcd_in;
            end
            if (boundary && pending) begin
                active <= shadow;
            end
            // Set dominates clear: a capture landing on the boundary stays queued.
            if (capture) begin
                pending <= 1'b1;
            end else if (boundary) begin
                pending <= 1'b0;
            end
        end
    end

    assign digit_code = active[{idx_next, 2'b00} +: 4];

    rtt_seg7_decode u_decode (
        .code (digit_code),
        .seg  (digit_seg)
    );

    assign lz_mask[3] = (active[15:12] == 4'd0);
    assign lz_mask[2] = lz_mask[3] && (active[11:8] == 4'd0);
    assign lz_mask[1] = lz_mask[2] && (active[7:4] == 4'd0);
    assign lz_mask[0] = 1'b0;

    // Outputs are computed from the next state so they line up with the state register.
    assign show_on = (state_next == SHOW) && !blank_all && !(lzb_en && lz_mask[idx_next]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg         <= SEG_OFF;
            an          <= 4'hF;
            frame_start <= 1'b0;
        end else begin
            frame_start <= boundary;
            if (show_on) begin
                seg <= digit_seg;
                an  <= ~(4'b0001 << idx_next);
            end else begin
                seg <= SEG_OFF;
                an  <= 4'hF;
            end
        end
    end

endmodule
